// File: rtl/expr_pkg.sv
// expr_pkg: shared types and constants for the expression evaluator.
//   state_e  : parser state (IDLE / NUM / OP / ERR)
//   CH_*     : ASCII codes recognised by the grammar
//   is_digit : true for ASCII '0'..'9'
package expr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // expecting the first digit of an expression
        NUM  = 2'd1,  // a digit was just consumed
        OP   = 2'd2,  // an operator was just consumed
        ERR  = 2'd3   // malformed; sticky until '=' or clr
    } state_e;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_EQ   = 8'h3D;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/expr_eval_dp.sv
// expr_eval_dp: arithmetic datapath for expr_eval.
//   clk       : clock
//   clear     : synchronous clear of sum/term/overflow (highest priority)
//   load_term : term <= digit
//   mul_term  : term <= term * digit
//   add_sum   : sum <= sum + term, term <= 0
//   finish    : expression terminated; clear everything for the next one
//   digit     : operand value 0..9
//   fin_val   : sum + term truncated to W bits (the value '=' would latch)
//   fin_ovf   : sticky overflow OR overflow of the final sum + term
//   acc_ovf   : sticky overflow only
module expr_eval_dp
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load_term,
    input  logic         mul_term,
    input  logic         add_sum,
    input  logic         finish,
    input  logic [3:0]   digit,
    output logic [W-1:0] fin_val,
    output logic         fin_ovf,
    output logic         acc_ovf
);

    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] term_q, term_d;
    logic         ovf_acc_q, ovf_acc_d;

    // Both operations are evaluated at W+4 bits; any set bit above W means
    // the truncated W-bit value lost information.
    logic [W+3:0] prod_w;
    logic [W+3:0] add_w;
    logic         prod_ovf;
    logic         add_ovf;

    always_comb begin
        prod_w   = {4'b0, term_q} * {{W{1'b0}}, digit};
        add_w    = {4'b0, sum_q} + {4'b0, term_q};
        prod_ovf = |prod_w[W+3:W];
        add_ovf  = |add_w[W+3:W];
    end

    always_comb begin
        sum_d     = sum_q;
        term_d    = term_q;
        ovf_acc_d = ovf_acc_q;
        if (finish) begin
            sum_d     = '0;
            term_d    = '0;
            ovf_acc_d = 1'b0;
        end else if (load_term) begin
            term_d = {{(W-4){1'b0}}, digit};
        end else if (mul_term) begin
            term_d    = prod_w[W-1:0];
            ovf_acc_d = ovf_acc_q | prod_ovf;
        end else if (add_sum) begin
            sum_d     = add_w[W-1:0];
            term_d    = '0;
            ovf_acc_d = ovf_acc_q | add_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sum_q     <= '0;
            term_q    <= '0;
            ovf_acc_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            term_q    <= term_d;
            ovf_acc_q <= ovf_acc_d;
        end
    end

    assign fin_val = add_w[W-1:0];
    assign fin_ovf = ovf_acc_q | add_ovf;
    assign acc_ovf = ovf_acc_q;

endmodule

// File: rtl/expr_eval.sv
// expr_eval: checks an ASCII stream of single-digit operands, '+' and '*'
// against the expression grammar and evaluates it ('*' binds tighter).
// '=' terminates an expression, latches the result and re-arms.
//   clk      : clock
//   clr      : synchronous active-high reset, priority over in_valid
//   in_valid : qualifies in
//   in       : ASCII character
//   ok       : prefix since last start is a complete valid expression
//   done     : one-cycle pulse the cycle after '=' is consumed
//   done_err : with done; expression was malformed
//   result   : value of the last valid expression (holds otherwise)
//   ovf      : with done; some intermediate value exceeded 2^W-1
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic         ok,
    output logic         done,
    output logic         done_err,
    output logic [W-1:0] result,
    output logic         ovf
);

    state_e       state_q, state_d;
    logic         mul_pending_q, mul_pending_d;
    logic         ok_q, ok_d;
    logic         done_q, done_d;
    logic         done_err_q, done_err_d;
    logic [W-1:0] result_q, result_d;
    logic         ovf_q, ovf_d;

    logic         load_term, mul_term, add_sum, finish;
    logic [W-1:0] fin_val;
    logic         fin_ovf, acc_ovf;

    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
    logic [3:0]   digit;
    assign digit = in[3:0];

    always_comb begin
        state_d       = state_q;
        mul_pending_d = mul_pending_q;
        done_d        = 1'b0;
        done_err_d    = done_err_q;
        result_d      = result_q;
        ovf_d         = ovf_q;
        load_term     = 1'b0;
        mul_term      = 1'b0;
        add_sum       = 1'b0;
        finish        = 1'b0;

        if (in_valid) begin
            case (in)
                CH_PLUS: begin
                    if (state_q == NUM) begin
                        add_sum       = 1'b1;
                        mul_pending_d = 1'b0;
                        state_d       = OP;
                    end else begin
                        state_d = ERR;
                    end
                end
                CH_STAR: begin
                    if (state_q == NUM) begin
                        mul_pending_d = 1'b1;
                        state_d       = OP;
                    end else begin
                        state_d = ERR;
                    end
                end
                CH_EQ: begin
                    done_d     = 1'b1;
                    done_err_d = (state_q != NUM);
                    if (state_q == NUM) begin
                        result_d = fin_val;
                        ovf_d    = fin_ovf;
                    end else begin
                        ovf_d = acc_ovf;
                    end
                    finish        = 1'b1;
                    mul_pending_d = 1'b0;
                    state_d       = IDLE;
                end
                default: begin
                    if (is_digit(in) && (state_q == IDLE || state_q == OP)) begin
                        // mul_pending is only ever set in OP, so IDLE always loads
                        if (mul_pending_q) mul_term  = 1'b1;
                        else               load_term = 1'b1;
                        state_d = NUM;
                    end else begin
                        state_d = ERR;
                    end
                end
            endcase
        end

        ok_d = (state_d == NUM);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= IDLE;
            mul_pending_q <= 1'b0;
            ok_q          <= 1'b0;
            done_q        <= 1'b0;
            done_err_q    <= 1'b0;
            result_q      <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mul_pending_q <= mul_pending_d;
            ok_q          <= ok_d;
            done_q        <= done_d;
            done_err_q    <= done_err_d;
            result_q      <= result_d;
            ovf_q         <= ovf_d;
        end
    end

    expr_eval_dp #(.W(W)) u_dp (
        .clk       (clk),
        .clear     (clr),
        .load_term (load_term),
        .mul_term  (mul_term),
        .add_sum   (add_sum),
        .finish    (finish),
        .digit     (digit),
        .fin_val   (fin_val),
        .fin_ovf   (fin_ovf),
        .acc_ovf   (acc_ovf)
    );

    assign ok       = ok_q;
    assign done     = done_q;
    assign done_err = done_err_q;
    assign result   = result_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: a W=16 and a W=4 instance share one input stream and
// are compared against a string-level evaluator after every character.
module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_ch;

    logic        ok16, done16, derr16, ovf16;
    logic [15:0] res16;
    logic        ok4, done4, derr4, ovf4;
    logic [3:0]  res4;

    always #5 clk = ~clk;

    expr_eval #(.W(16)) dut16 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
        .ok(ok16), .done(done16), .done_err(derr16), .result(res16), .ovf(ovf16)
    );

    expr_eval #(.W(4)) dut4 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
        .ok(ok4), .done(done4), .done_err(derr4), .result(res4), .ovf(ovf4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    byte         cur[$];      // characters of the expression in progress
    logic [15:0] exp_res16;
    logic [3:0]  exp_res4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Grammar: d (op d)* with single digits and op in {+,*}.
    function automatic bit well_formed(input byte q[$]);
        if (q.size() == 0 || (q.size() % 2) == 0) return 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (i % 2 == 0) begin
                if (q[i] < 8'h30 || q[i] > 8'h39) return 1'b0;
            end else begin
                if (q[i] != 8'h2B && q[i] != 8'h2A) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // Left-to-right evaluation with '*' precedence; every intermediate
    // product/sum is reduced mod 2^w and flags overflow if it did not fit.
    function automatic void eval_expr(input byte q[$], input int w,
                                      output longint val, output bit ov);
        longint mask = (64'd1 << w) - 1;
        longint sum  = 0;
        longint term = longint'(q[0] - 8'h30);
        longint t;
        ov = 1'b0;
        for (int i = 1; i + 1 < q.size(); i += 2) begin
            longint d = longint'(q[i+1] - 8'h30);
            if (q[i] == 8'h2A) begin
                t = term * d;
                if (t > mask) ov = 1'b1;
                term = t & mask;
            end else begin
                t = sum + term;
                if (t > mask) ov = 1'b1;
                sum  = t & mask;
                term = d;
            end
        end
        t = sum + term;
        if (t > mask) ov = 1'b1;
        val = t & mask;
    endfunction

    task automatic send_char(input byte c);
        longint v16, v4;
        bit     o16, o4, good;
        in_ch    = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (c == 8'h3D) begin
            good = well_formed(cur);
            chk("done16", done16, 1);
            chk("done4",  done4,  1);
            chk("derr16", derr16, !good);
            chk("derr4",  derr4,  !good);
            if (good) begin
                eval_expr(cur, 16, v16, o16);
                eval_expr(cur, 4,  v4,  o4);
                exp_res16 = v16[15:0];
                exp_res4  = v4[3:0];
                chk("ovf16", ovf16, o16);
                chk("ovf4",  ovf4,  o4);
            end
            chk("res16", res16, exp_res16);
            chk("res4",  res4,  exp_res4);
            chk("ok_eq", ok16, 0);
            cur.delete();
        end else begin
            cur.push_back(c);
            good = well_formed(cur);
            chk("done16_q", done16, 0);
            chk("ok16", ok16, good);
            chk("ok4",  ok4,  good);
        end
    endtask

    task automatic idle_cycle();
        in_ch    = 8'($urandom);
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_done16", done16, 0);
        chk("gap_done4",  done4,  0);
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (gaps) idle_cycle();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ok"},   {ok16, ok4}, 0);
        chk({tag, "_done"}, {done16, done4}, 0);
        chk({tag, "_derr"}, {derr16, derr4}, 0);
        chk({tag, "_res"},  {res16, res4}, 0);
        chk({tag, "_ovf"},  {ovf16, ovf4}, 0);
    endtask

    task automatic do_clr();
        clr      = 1'b1;
        in_valid = 1'(($urandom));
        in_ch    = 8'h31;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        cur.delete();
        exp_res16 = '0;
        exp_res4  = '0;
        check_reset_outputs("rst");
    endtask

    initial begin
        string bad_list[5];
        byte   ops[4];
        clr = 1'b1; in_valid = 1'b0; in_ch = 8'h00;
        exp_res16 = '0; exp_res4 = '0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        check_reset_outputs("init");

        send_str("2+3*4=", 1'b0);
        chk("lit_14", res16, 14);
        send_str("1*2*3+4*5=", 1'b1);
        chk("lit_26", res16, 26);

        bad_list = '{"+1=", "12=", "3*=", "4a5=", "="};
        foreach (bad_list[i]) begin
            send_str(bad_list[i], 1'b0);
            chk("lit_hold26", res16, 26);
        end
        send_char(8'h3D);  // back-to-back '=' in IDLE

        send_str("9*9=", 1'b0);
        chk("lit_w4_81", {ovf4, res4}, {1'b1, 4'd1});
        send_str("7+8=", 1'b0);
        chk("lit_w4_15", {ovf4, res4}, {1'b0, 4'd15});
        send_str("8+8=", 1'b0);
        chk("lit_w4_16", {ovf4, res4}, {1'b1, 4'd0});

        send_str("5*", 1'b0);
        do_clr();
        send_str("7=", 1'b0);
        chk("lit_after_clr", {derr16, res16}, {1'b0, 16'd7});

        // clr coincident with '=' wins: no done pulse, everything reset
        send_str("3+", 1'b0);
        in_ch = 8'h3D; in_valid = 1'b1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        cur.delete(); exp_res16 = '0; exp_res4 = '0;
        check_reset_outputs("clr_eq");

        ops = '{8'h2B, 8'h2A, 8'h61, 8'h20};
        for (int n = 0; n < 150; n++) begin
            int nd = int'($urandom_range(1, 6));
            for (int k = 0; k < nd; k++) begin
                byte c = byte'(8'h30 + $urandom_range(0, 9));
                if ($urandom_range(0, 19) == 0) c = ops[$urandom_range(0, 3)];
                send_char(c);
                if ($urandom_range(0, 3) == 0) idle_cycle();
                if (k != nd - 1) begin
                    c = ($urandom_range(0, 1) == 0) ? 8'h2B : 8'h2A;
                    if ($urandom_range(0, 19) == 0) c = ops[$urandom_range(0, 3)];
                    send_char(c);
                end
            end
            send_char(8'h3D);
            if ($urandom_range(0, 4) == 0) idle_cycle();
            if ($urandom_range(0, 29) == 0) do_clr();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
Downstream consumer of the character-stream expression checker. It takes the same 8-bit ASCII stream (single-digit operands, '+' and '*'), checks it against the same grammar, and computes the arithmetic value with '*' binding tighter than '+'. An '=' character ends the expression: the block latches the result, pulses a done strobe and re-arms for the next expression.

Parameters:
W, 16, result/accumulator width in bits; all arithmetic is modulo 2^W.

Ports:
clk  in  1  system clock; all state updates on posedge clk
clr  in  1  reset, synchronous, active-high
in_valid  in  1  qualifies in; character consumed on posedge clk when 1
in  in  8  ASCII character
ok  out  1  1 when the prefix consumed since the last start is a complete valid expression (state NUM)
done  out  1  one-cycle pulse on the cycle after '=' is consumed
done_err  out  1  valid with done; 1 = expression was malformed, result meaningless
result  out  W  value of the last terminated expression; holds until the next '='
ovf  out  1  valid with done; 1 = some intermediate sum or product exceeded 2^W-1

Behaviour:
- Reset (clr=1 at posedge): state=IDLE, sum=0, term=0, mul_pending=0, ovf_acc=0; outputs ok=0, done=0, done_err=0, result=0, ovf=0. clr has priority over in_valid.
- in_valid=0: no state change; done drops to 0; all other registers hold.
- States: IDLE (expect first digit), NUM (digit just seen), OP (operator just seen), ERR (sticky malformed).
- Digit d (ASCII '0'-'9', value in-8'h30):
  - IDLE or OP with mul_pending=0: term <= d.
  - OP with mul_pending=1: term <= term*d.
  - In both cases state <= NUM.
  - NUM or ERR: state <= ERR.
- '+':
  - In NUM: sum <= sum+term, term <= 0, mul_pending <= 0, state <= OP.
  - Otherwise: ERR.
- '*':
  - In NUM: mul_pending <= 1, state <= OP; term is kept.
  - Otherwise: ERR.
- '=':
  - From any state: done <= 1.
  - done_err <= (state != NUM).
  - result <= sum+term when state == NUM, otherwise result holds.
  - ovf <= ovf_acc, or overflow of the final add.
  - Then sum, term, mul_pending and ovf_acc clear and state <= IDLE; the next character starts a new expression.
- Any other character: ERR. ERR persists until '=' or clr.
- ok = (state==NUM), registered; it is visible the cycle after the digit is consumed.
- Arithmetic: products and sums are computed at W+4 bits and truncated to W. If any discarded bit is nonzero, ovf_acc is set (sticky within the expression).
- Latency: result, done, done_err and ovf are valid exactly 1 cycle after '=' is sampled. Back-to-back '=' is legal: each one produces its own done pulse, and an '=' seen in IDLE gives done_err=1.
- clr mid-expression discards all partial state. A done pulse in flight is cleared with it.

Decomposition:
- Package expr_pkg:
  - State enum IDLE/NUM/OP/ERR.
  - ASCII constants CH_0, CH_9, CH_PLUS, CH_STAR, CH_EQ.
  - is_digit function.
- Sub-module expr_eval_dp: sum/term registers, W+4 multiply and add, overflow detection.
  - Controlled by the FSM with strobes load_term, mul_term, add_sum, finish, clear.

Test Plan:
- clr; stream "2+3*4=" with in_valid=1 each cycle -> done=1 one cycle after '=', result=14, done_err=0, ovf=0.
- "1*2*3+4*5=" -> result=26.
  - ok is 1 after each digit and 0 after each operator.
  - Inserting in_valid=0 gaps between characters does not change the outcome.
- Malformed inputs each give done=1, done_err=1, and result still holding 26:
  - "+1="
  - "12="
  - "3*="
  - "4a5="
  - lone "="
- W=4: "9*9=" -> result=1 (81 mod 16), ovf=1.
  - Then "7+8=" -> result=15, ovf=0.
  - Then "8+8=" -> result=0, ovf=1.
- "5*" then clr=1 for one cycle, then "7=" -> result=7, done_err=0.
  - Assert clr in the same cycle as an '=' -> no done pulse, and all outputs return to reset values.
